fifo_rd_packer: RTL
===================

Name: fifo_rd_packer

Overview:
Read-side consumer of the async FIFO, running in the FIFO read clock domain. It drains DW-bit entries through the FIFO's r_en/empty/data_out interface and packs NPACK entries, LSB-first, into one wide word. The word is presented on a valid/ready output with a holding register. A flush request emits a partial, zero-padded word, so downstream logic never has to handle nibble-level traffic.

Parameters:
DW, 4, width of one FIFO entry.
NPACK, 4, FIFO entries packed per output word.
CW, 8, width of the output word counter.

Ports:
rclk  in  1  read-domain clock; all logic is on its rising edge.
rstn  in  1  reset, asynchronous assert, active-low.
fifo_empty  in  1  empty flag from the FIFO read side.
fifo_data  in  DW  FIFO data_out; valid one cycle after the fifo_ren edge.
fifo_ren  out  1  read enable to the FIFO (r_en).
flush  in  1  single-cycle request to emit the partial word.
o_ready  in  1  downstream accepts o_data.
o_valid  out  1  o_data/o_nib valid.
o_data  out  DW*NPACK  packed word; entry 0 sits in bits [DW-1:0].
o_nib  out  clog2(NPACK+1)  number of valid entries in o_data (1..NPACK).
flush_done  out  1  one-cycle pulse when the flush has completed.
busy  out  1  high when any assembly entry, in-flight read or held word exists.
word_cnt  out  CW  count of accepted words (o_valid && o_ready); wraps modulo 2^CW.

Behaviour:
- Reset (rstn low, async): fifo_ren=0, o_valid=0, o_data=0, o_nib=0, flush_done=0, busy=0, word_cnt=0, cnt=0, pend=0, state=FILL.
  - Assertion mid-operation discards the partial word, any in-flight read and the held word.
  - Data returning after reset release is ignored, because pend is cleared.
- Internal state:
  - cnt: entries in the assembly register, 0..NPACK.
  - pend: registered copy of fifo_ren, meaning fifo_data is valid this cycle.
- fifo_ren is combinational: !fifo_empty && state==FILL && (cnt+pend < NPACK).
  - It is never high while fifo_empty is high, so the FIFO never underflows.
- Capture: at a rising edge with pend=1, fifo_data is written into slot cnt and cnt increments.
- Transfer to the output register happens when cnt==NPACK (including the edge that makes it NPACK) and the output register is free.
  - "Free" means o_valid==0, or o_valid && o_ready at that same edge.
  - On transfer: o_valid=1, o_nib=NPACK, cnt=0.
  - Latency: the last entry's fifo_ren edge k gives o_valid high after edge k+1.
  - Peak throughput is NPACK entries per NPACK+1 cycles (one-cycle bubble per word).
- Backpressure: if the output register is held, assembly fills to NPACK and then stalls, with fifo_ren low, until o_ready.
- o_data and o_nib are stable while o_valid && !o_ready.
- word_cnt increments on every o_valid && o_ready edge; it wraps from 2^CW-1 to 0.
- State machine FILL / FLUSH:
  - FILL: flush=1 moves to FLUSH and blocks new reads. A flush while already in FLUSH is ignored.
  - FLUSH, waiting: stays in FLUSH until pend==0 (the in-flight entry has been captured).
  - FLUSH, cnt==0: the flush_done pulse is issued and the state returns to FILL; no word is emitted.
  - FLUSH, cnt>0 with the output register free: transfers the partial word (o_nib=cnt, unused upper slots zero), pulses flush_done the same edge, cnt=0, returns to FILL.
  - FLUSH, cnt>0 with the output register held: waits in FLUSH.
- A flush with cnt==NPACK is handled as a normal full transfer, with o_nib=NPACK.
- Simultaneous capture and transfer in one edge is legal. Slot indexing uses the pre-edge cnt.

Decomposition:
- The shared package holds:
  - the state typedef (FILL, FLUSH);
  - the defaults DW_DEF=4, NPACK_DEF=4;
  - a clog2 function for the o_nib width.
- One sub-module is natural: rd_pack_asm, the assembly register with its slot write, cnt and zero-padding.
  - Top level keeps fifo_ren/pend, the state machine, the output register and word_cnt.

Test Plan:
- Sanity: FIFO holds 1,2,3,4, o_ready=1 -> one word o_data=16'h4321, o_nib=4, word_cnt=1, fifo_ren never high with fifo_empty.
- Backpressure: 12 entries 0..B, o_ready=0 -> exactly 8 fifo_ren pulses, o_data=16'h3210 held stable. Raise o_ready -> words 16'h7654, 16'hBA98 in order, word_cnt=3.
- Partial flush: entries A,B,C then flush -> o_data=16'h0CBA, o_nib=3, flush_done pulses on the transfer edge, busy low afterwards.
- Flush racing a read: flush asserted in the cycle after fifo_ren for the 2nd entry (entries 5,6) -> the in-flight entry is captured, o_data=16'h0065, o_nib=2, no further fifo_ren until flush_done.
- Empty flush and reset: flush with nothing buffered -> flush_done next edge, o_valid stays 0. Reset after 2 of 4 entries -> all outputs 0; next entries 7,8,9,A -> o_data=16'hA987.
- Wrap: 256 words accepted with CW=8 -> word_cnt returns to 0.

Source files
------------

// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and defaults for the FIFO read-side packer.
// Imported by the packer top and its assembly register.
package fifo_rd_packer_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int DW_DEF    = 4;
    localparam int NPACK_DEF = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_asm.sv
// Assembly register: slots filled LSB-first, cleared on transfer.
// Cleared slots provide the zero padding of partial words.
module rd_pack_asm
    import fifo_rd_packer_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int NPACK = NPACK_DEF,
    parameter int NW    = clog2(NPACK + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cap,
    input  logic [DW-1:0]       cap_data,
    input  logic                clr,
    output logic [NW-1:0]       cnt,
    output logic [NW-1:0]       cnt_nxt,
    output logic [DW*NPACK-1:0] word_nxt
);

    logic [DW-1:0] slot_q [NPACK];
    logic [NW-1:0] cnt_q;

    assign cnt = cnt_q;

    // word_nxt already includes an entry captured on this edge
    always_comb begin
        cnt_nxt  = cnt_q + NW'(cap);
        word_nxt = '0;
        for (int i = 0; i < NPACK; i++) begin
            word_nxt[i*DW +: DW] = slot_q[i];
            if (cap && cnt_q == NW'(i)) begin
                word_nxt[i*DW +: DW] = cap_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < NPACK; i++) begin
                slot_q[i] <= '0;
            end
        end else if (clr) begin
            cnt_q <= '0;
            for (int i = 0; i < NPACK; i++) begin
                slot_q[i] <= '0;
            end
        end else if (cap) begin
            cnt_q <= cnt_nxt;
            for (int i = 0; i < NPACK; i++) begin
                if (cnt_q == NW'(i)) begin
                    slot_q[i] <= cap_data;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains the async FIFO read side and packs NPACK entries per word.
// Flush emits a zero-padded partial word; output has a holding register.
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int NPACK = NPACK_DEF,
    parameter int CW    = 8
) (
    input  logic                        rclk,
    input  logic                        rstn,
    input  logic                        fifo_empty,
    input  logic [DW-1:0]               fifo_data,
    output logic                        fifo_ren,
    input  logic                        flush,
    input  logic                        o_ready,
    output logic                        o_valid,
    output logic [DW*NPACK-1:0]         o_data,
    output logic [clog2(NPACK+1)-1:0]   o_nib,
    output logic                        flush_done,
    output logic                        busy,
    output logic [CW-1:0]               word_cnt
);

    localparam int NW = clog2(NPACK + 1);

    state_t                state_q;
    logic                  pend_q;
    logic [NW-1:0]         cnt;
    logic [NW-1:0]         cnt_nxt;
    logic [DW*NPACK-1:0]   word_nxt;
    logic                  free;
    logic                  full_x;
    logic                  fl_idle;
    logic                  xfer;
    logic                  done;

    rd_pack_asm #(
        .DW    (DW),
        .NPACK (NPACK),
        .NW    (NW)
    ) u_asm (
        .clk      (rclk),
        .rst_n    (rstn),
        .cap      (pend_q),
        .cap_data (fifo_data),
        .clr      (xfer),
        .cnt      (cnt),
        .cnt_nxt  (cnt_nxt),
        .word_nxt (word_nxt)
    );

    // Count in-flight reads so the assembly never overfills
    assign fifo_ren = !fifo_empty && state_q == FILL
                    && (int'(cnt) + int'(pend_q) < NPACK);

    assign free    = !o_valid || o_ready;
    assign full_x  = cnt_nxt == NW'(NPACK);
    assign fl_idle = state_q == FLUSH && !pend_q;
    assign xfer    = free && (full_x || (fl_idle && cnt != '0));
    assign done    = fl_idle && (cnt == '0 || xfer);
    assign busy    = cnt != '0 || pend_q || o_valid;

    always_ff @(posedge rclk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= FILL;
            pend_q     <= 1'b0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_nib      <= '0;
            flush_done <= 1'b0;
            word_cnt   <= '0;
        end else begin
            pend_q     <= fifo_ren;
            flush_done <= done;
            if (o_valid && o_ready) begin
                word_cnt <= word_cnt + CW'(1);
            end
            if (xfer) begin
                o_valid <= 1'b1;
                o_data  <= word_nxt;
                o_nib   <= cnt_nxt;
            end else if (o_ready) begin
                o_valid <= 1'b0;
            end
            unique case (state_q)
                FILL:  if (flush) state_q <= FLUSH;
                FLUSH: if (done)  state_q <= FILL;
                default: state_q <= FILL;
            endcase
        end
    end

endmodule
